// File: rtl/instruction_cache_controller_if.sv
// Fetch, memory-refill and cache-array signals of the I-cache controller.
// slave is the controller side, master the surrounding fetch/mem/array side.
interface instruction_cache_controller_if;
  logic        fetch_i;
  logic [31:0] fetch_address_i;
  logic        flush_i;
  logic        stall_o;
  logic        instruction_valid_o;
  logic        mem_request_o;
  logic [31:0] mem_address_o;
  logic        mem_valid_i;
  logic [31:0] mem_data_i;
  logic [31:0] cache_read_address_o;
  logic [2:0]  cache_read_o;
  logic        cache_hit_i;
  logic [31:0] cache_write_address_o;
  logic [2:0]  cache_write_o;
  logic [31:0] cache_instruction_o;
  logic        cache_valid_o;

  modport slave (
    input  fetch_i, fetch_address_i, flush_i,
    input  mem_valid_i, mem_data_i, cache_hit_i,
    output stall_o, instruction_valid_o,
    output mem_request_o, mem_address_o,
    output cache_read_address_o, cache_read_o,
    output cache_write_address_o, cache_write_o,
    output cache_instruction_o, cache_valid_o
  );

  modport master (
    output fetch_i, fetch_address_i, flush_i,
    output mem_valid_i, mem_data_i, cache_hit_i,
    input  stall_o, instruction_valid_o,
    input  mem_request_o, mem_address_o,
    input  cache_read_address_o, cache_read_o,
    input  cache_write_address_o, cache_write_o,
    input  cache_instruction_o, cache_valid_o
  );
endinterface

// File: rtl/instruction_cache_controller.sv
// I-cache sequencer: lookup, block refill on miss, and full
// invalidation sweep after reset or flush.
module instruction_cache_controller #(
  parameter int CACHE_SIZE = 8192,
  parameter int BLOCK_SIZE = 16,
  parameter int TAG_SIZE   = 20
) (
  input logic clk_i,
  input logic rst_i,
  instruction_cache_controller_if.slave bus
);
  localparam int INDEX   = $clog2(CACHE_SIZE / BLOCK_SIZE);
  localparam int WORDS   = BLOCK_SIZE / 4;
  localparam int WB      = $clog2(WORDS);
  localparam int OFS     = $clog2(BLOCK_SIZE);
  localparam int TAG_LSB = 32 - TAG_SIZE;
  localparam logic [INDEX-1:0] LAST_IDX  = '1;
  localparam logic [WB-1:0]    LAST_WORD = WB'(WORDS - 1);

  typedef enum logic [2:0] {
    INIT, IDLE, COMPARE, REFILL, REPLAY
  } state_t;

  state_t           state_q, state_d;
  logic [INDEX-1:0] sweep_q, sweep_d;
  logic [WB-1:0]    word_q, word_d;
  logic [31:0]      addr_q, addr_d;
  logic             flush_q, flush_d;

  // Tag and the bits between tag and block offset, kept apart so the
  // refill address is rebuilt as {tag, index, word, 2'b00}.
  logic [TAG_SIZE-1:0]    tag;
  logic [TAG_LSB-OFS-1:0] mid;
  assign tag = addr_q[31:TAG_LSB];
  assign mid = addr_q[TAG_LSB-1:OFS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= INIT;
      sweep_q <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    word_d  = word_q;
    addr_d  = addr_q;
    flush_d = flush_q;

    bus.stall_o               = 1'b1;
    bus.instruction_valid_o   = 1'b0;
    bus.mem_request_o         = 1'b0;
    bus.mem_address_o         = {addr_q[31:OFS], {OFS{1'b0}}};
    bus.cache_read_address_o  = addr_q;
    bus.cache_read_o          = 3'b000;
    bus.cache_write_address_o = {tag, mid, word_q, 2'b00};
    bus.cache_write_o         = 3'b000;
    bus.cache_instruction_o   = bus.mem_data_i;
    bus.cache_valid_o         = 1'b0;

    unique case (state_q)
      INIT: begin
        bus.cache_write_address_o =
          {{(32-INDEX-OFS){1'b0}}, sweep_q, {OFS{1'b0}}};
        // No array writes while reset is still held.
        bus.cache_write_o = rst_i ? 3'b000 : 3'b010;
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == LAST_IDX) state_d = IDLE;
      end
      IDLE: begin
        bus.stall_o = 1'b0;
        if (bus.flush_i) begin
          state_d = INIT;
        end else if (bus.fetch_i) begin
          bus.cache_read_o         = 3'b111;
          bus.cache_read_address_o = bus.fetch_address_i;
          addr_d  = bus.fetch_address_i;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (bus.cache_hit_i) begin
          bus.instruction_valid_o = 1'b1;
          bus.stall_o = 1'b0;
          if (bus.flush_i) begin
            state_d = INIT;
          end else if (bus.fetch_i) begin
            bus.cache_read_o         = 3'b111;
            bus.cache_read_address_o = bus.fetch_address_i;
            addr_d = bus.fetch_address_i;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bus.mem_request_o = 1'b1;
          word_d  = '0;
          flush_d = bus.flush_i;
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (bus.flush_i) flush_d = 1'b1;
        if (bus.mem_valid_i) begin
          bus.cache_write_o = 3'b100;
          word_d = word_q + 1'b1;
          if (word_q == LAST_WORD) begin
            bus.cache_write_o = 3'b111;
            bus.cache_valid_o = 1'b1;
            state_d = REPLAY;
          end
        end
      end
      REPLAY: begin
        if (flush_q) begin
          flush_d = 1'b0;
          state_d = INIT;
        end else begin
          bus.cache_read_o = 3'b111;
          state_d = COMPARE;
        end
      end
      default: state_d = INIT;
    endcase
  end
endmodule
